// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit: ALU ops, opcodes, functs, states.
// ILLEGAL_TRAP_EN adds the HALT state used to trap undefined instructions.
package multi_cycle_controller_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
`ifdef ILLEGAL_TRAP_EN
    S_JUMP   = 3'd5,
    S_HALT   = 3'd6
`else
    S_JUMP   = 3'd5
`endif
  } state_t;

  typedef enum logic [1:0] {
    RT_EXEC    = 2'd0,
    RT_JUMP    = 2'd1,
    RT_ILLEGAL = 2'd2
  } route_t;

  typedef struct packed {
    logic reg_dst;
    logic jal_reg;
    logic pc_to_reg;
    logic alu_src;
    logic mem_to_reg;
    logic jump_sel;
    logic pc_jump;
  } sel_t;

  function automatic logic is_alu_fn(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
           (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

  function automatic route_t route(input logic [5:0] op, input logic [5:0] fn);
    route_t r;
    r = RT_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_JR)        r = RT_JUMP;
        else if (is_alu_fn(fn)) r = RT_EXEC;
      end
      OP_ADDI, OP_SLTI, OP_LW, OP_SW, OP_BEQ: r = RT_EXEC;
      OP_J, OP_JAL:                           r = RT_JUMP;
      default: ;
    endcase
    return r;
  endfunction

  // Datapath mux selects held for the whole instruction; undefined encodings select nothing.
  function automatic sel_t decode_sel(input logic [5:0] op, input logic [5:0] fn);
    sel_t s;
    s = '0;
    case (op)
      OP_RTYPE: begin
        if (fn == FN_JR)        s.pc_jump = 1'b1;
        else if (is_alu_fn(fn)) s.reg_dst = 1'b1;
      end
      OP_ADDI, OP_SLTI, OP_SW: s.alu_src = 1'b1;
      OP_LW: begin
        s.alu_src    = 1'b1;
        s.mem_to_reg = 1'b1;
      end
      OP_J: begin
        s.jump_sel = 1'b1;
        s.pc_jump  = 1'b1;
      end
      OP_JAL: begin
        s.jump_sel  = 1'b1;
        s.pc_jump   = 1'b1;
        s.jal_reg   = 1'b1;
        s.pc_to_reg = 1'b1;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multi_cycle_controller_alu_controller.sv
// Combinational ALU operation decode from opcode/funct.
module alu_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  output logic [2:0] alu_cntrl
);

  always_comb begin
    alu_cntrl = ALU_ADD;
    case (op)
      OP_BEQ:  alu_cntrl = ALU_SUB;
      OP_SLTI: alu_cntrl = ALU_SLT;
      OP_RTYPE: begin
        case (fn)
          FN_SUB:  alu_cntrl = ALU_SUB;
          FN_AND:  alu_cntrl = ALU_AND;
          FN_OR:   alu_cntrl = ALU_OR;
          FN_SLT:  alu_cntrl = ALU_SLT;
          default: alu_cntrl = ALU_ADD;
        endcase
      end
      default: alu_cntrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multi_cycle_controller.sv
// Moore control FSM for the multi-cycle MIPS-subset datapath.
// Build option ILLEGAL_TRAP_EN: undefined instructions halt with illegal=1 instead of running as NOPs.
module multi_cycle_controller
  import multi_cycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ZERO,
  input  logic       mem_ready,
  output logic       reg_dst,
  output logic       jal_reg,
  output logic       pc_to_reg,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       jump_sel,
  output logic       pc_jump,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic [2:0] alu_cntrl,
  output logic       pc_write,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state_q;
  logic [5:0] op_q;
  logic [5:0] fn_q;
  sel_t       sel_q;
  logic [2:0] alu_q;
  logic       reg_write_q;
  logic       mem_read_q;
  logic       mem_write_q;
  logic       pc_write_q;
  logic       done_q;
  logic       pc_src_en_q;
  logic [2:0] alu_next;
  route_t     rt;
  logic       is_lw;
  logic       is_sw;
  logic       sw_exit;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_q;
`endif

  // Decoded from the live instruction bits so the registered value lines up with op_q/fn_q in DECODE.
  alu_controller u_alu_controller (
    .op        (opcode),
    .fn        (funct),
    .alu_cntrl (alu_next)
  );

  assign rt    = route(op_q, fn_q);
  assign is_lw = (op_q == OP_LW);
  assign is_sw = (op_q == OP_SW);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      fn_q        <= '0;
      sel_q       <= '0;
      alu_q       <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
      pc_src_en_q <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q   <= 1'b0;
`endif
    end else begin
      // Strobes are registered for the state being entered and default low.
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      pc_write_q  <= 1'b0;
      done_q      <= 1'b0;
      pc_src_en_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          state_q <= S_DECODE;
          op_q    <= opcode;
          fn_q    <= funct;
          sel_q   <= decode_sel(opcode, funct);
          alu_q   <= alu_next;
`ifndef ILLEGAL_TRAP_EN
          if (route(opcode, funct) == RT_ILLEGAL) begin
            pc_write_q <= 1'b1;
            done_q     <= 1'b1;
          end
`endif
        end
        S_DECODE: begin
          case (rt)
            RT_EXEC: begin
              state_q <= S_EXEC;
              if (op_q == OP_BEQ) begin
                pc_write_q  <= 1'b1;
                done_q      <= 1'b1;
                pc_src_en_q <= 1'b1;
              end
            end
            RT_JUMP: begin
              state_q     <= S_JUMP;
              pc_write_q  <= 1'b1;
              done_q      <= 1'b1;
              reg_write_q <= (op_q == OP_JAL);
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
              state_q   <= S_HALT;
              illegal_q <= 1'b1;
`else
              state_q   <= S_FETCH;
`endif
              sel_q     <= '0;
              alu_q     <= ALU_ADD;
            end
          endcase
        end
        S_EXEC: begin
          if (op_q == OP_BEQ) begin
            state_q <= S_FETCH;
            sel_q   <= '0;
            alu_q   <= ALU_ADD;
          end else if (is_lw || is_sw) begin
            state_q     <= S_MEM;
            mem_read_q  <= is_lw;
            mem_write_q <= is_sw;
          end else begin
            state_q     <= S_WB;
            reg_write_q <= 1'b1;
            pc_write_q  <= 1'b1;
            done_q      <= 1'b1;
          end
        end
        S_MEM: begin
          if (!mem_ready) begin
            state_q     <= S_MEM;
            mem_read_q  <= is_lw;
            mem_write_q <= is_sw;
          end else if (is_lw) begin
            state_q     <= S_WB;
            reg_write_q <= 1'b1;
            pc_write_q  <= 1'b1;
            done_q      <= 1'b1;
          end else begin
            state_q <= S_FETCH;
            sel_q   <= '0;
            alu_q   <= ALU_ADD;
          end
        end
        S_WB, S_JUMP: begin
          state_q <= S_FETCH;
          sel_q   <= '0;
          alu_q   <= ALU_ADD;
        end
`ifdef ILLEGAL_TRAP_EN
        S_HALT: begin
          state_q <= S_HALT;
        end
`endif
        default: begin
          state_q <= S_FETCH;
          sel_q   <= '0;
          alu_q   <= ALU_ADD;
        end
      endcase
    end
  end

  // A store retires in the MEM cycle where memory completes, so its PC update follows mem_ready.
  assign sw_exit = (state_q == S_MEM) && is_sw && mem_ready;

  assign reg_dst    = sel_q.reg_dst;
  assign jal_reg    = sel_q.jal_reg;
  assign pc_to_reg  = sel_q.pc_to_reg;
  assign alu_src    = sel_q.alu_src;
  assign mem_to_reg = sel_q.mem_to_reg;
  assign jump_sel   = sel_q.jump_sel;
  assign pc_jump    = sel_q.pc_jump;
  assign pc_src     = pc_src_en_q & ZERO;
  assign reg_write  = reg_write_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign alu_cntrl  = alu_q;
  assign pc_write   = pc_write_q | sw_exit;
  assign instr_done = done_q | sw_exit;
`ifdef ILLEGAL_TRAP_EN
  assign illegal    = illegal_q;
`else
  assign illegal    = 1'b0;
`endif

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Control unit for the MIPS-subset datapath. It runs each instruction through a Moore state machine and drives every datapath control input (`reg_dst`, `jal_reg`, `pc_to_reg`, `alu_src`, `mem_to_reg`, `jump_sel`, `pc_jump`, `pc_src`, `reg_write`, `mem_read`, `mem_write`, `alu_cntrl`). It also drives a `pc_write` enable, so the PC and register file update once per instruction. It sits directly upstream of the datapath: it consumes `instructs[31:26]`, `instructs[5:0]` and `ZERO`, and it stalls on data-memory wait states through `mem_ready`.

## Interface
- No parameters; opcode/funct/ALU encodings come from the shared header.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `opcode` in 6: `instructs[31:26]`.
- `funct` in 6: `instructs[5:0]`.
- `ZERO` in 1: ALU zero flag.
- `mem_ready` in 1: data memory has completed the access this cycle.
- `reg_dst`, `jal_reg`, `pc_to_reg`, `alu_src`, `mem_to_reg`, `jump_sel`, `pc_jump`, `pc_src` out 1 each: datapath mux selects.
- `reg_write`, `mem_read`, `mem_write` out 1 each: strobes.
- `alu_cntrl` out 3: ALU operation.
- `pc_write` out 1: PC load enable.
- `instr_done` out 1: one-cycle pulse in the final state of each instruction.
- `illegal` out 1: undefined-instruction flag (see Configuration).

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, JUMP, HALT. Encoding is 3-bit and kept in the shared header.
- FETCH → DECODE, always. At this edge `opcode` and `funct` are registered into `op_q` and `fn_q`.
- DECODE routes on `op_q`:
  - R-type (000000), addi (001000), slti (001010), lw (100011), sw (101011), beq (000100) → EXEC.
  - j (000010), jal (000011), and R-type with `fn_q`=001000 (jr) → JUMP.
  - Anything else → illegal handling.
- EXEC:
  - beq → FETCH, with `pc_write`=1 and `pc_src`=`ZERO`.
  - lw and sw → MEM.
  - All others → WB.
- MEM: `mem_read` (lw) or `mem_write` (sw) is held high. The FSM stays in MEM while `mem_ready`=0.
  - lw → WB when `mem_ready`=1.
  - sw → FETCH when `mem_ready`=1, with `pc_write`=1.
- WB: `reg_write`=1 and `pc_write`=1 → FETCH.
  - lw: `mem_to_reg`=1.
  - R-type: `reg_dst`=1.
  - addi/slti: `alu_src`=1.
- JUMP: `pc_jump`=1 and `pc_write`=1 → FETCH.
  - `jump_sel`=1 for j/jal; `jump_sel`=0 for jr.
  - jal additionally drives `jal_reg`=1, `pc_to_reg`=1, `reg_write`=1.
- Mux selects and `alu_cntrl` come only from `op_q`/`fn_q` and are stable from DECODE to the end of the instruction. In FETCH all selects are 0 and `alu_cntrl`=`ADD`.
- `alu_cntrl` values:
  - lw/sw/addi: `ADD`.
  - beq: `SUB`.
  - slti: `SLT`.
  - R-type by funct: 100000 `ADD`, 100010 `SUB`, 100100 `AND`, 100101 `OR`, 101010 `SLT`.
- `pc_src` is 0 in every state except EXEC of beq.
- `instr_done` is high in the state that asserts `pc_write`, and only then.

## Timing
- Reset (`rst`=0) asynchronously forces state FETCH, `op_q`/`fn_q`=0 and every output to 0 (including strobes, `pc_write` and `illegal`).
- The first FETCH begins on the first rising edge after `rst` rises.
- Outputs are Moore (decoded from state and `op_q`/`fn_q`). The exceptions are `pc_src` (follows `ZERO` combinationally in beq EXEC) and the MEM exit, which depends on `mem_ready` sampled at the edge.
- Latency in cycles, with `mem_ready` tied to 1:
  - R-type, addi, slti: 4.
  - lw: 5.
  - sw: 4.
  - beq, j, jal, jr: 3.
  - Each cycle `mem_ready` is 0 in MEM adds one cycle.
- `reg_write` and `pc_write` are each high for exactly one cycle per instruction. `mem_read`/`mem_write` are high for every MEM cycle.
- If reset is asserted mid-MEM, the strobes drop in the same cycle and no `pc_write` occurs.

## Configuration
- `ILLEGAL_TRAP_EN` defined:
  - An undefined opcode, or an undefined R-type funct, goes DECODE → HALT.
  - In HALT all strobes are 0 and `illegal`=1. The FSM stays in HALT until reset.
- `ILLEGAL_TRAP_EN` undefined:
  - An undefined instruction executes as a NOP: DECODE asserts `pc_write`=1 and `instr_done`=1 with all selects 0, then → FETCH.
  - `illegal` is tied 0 and the HALT state is not present.

## Structure
- The following belong in the shared `constant_values.h`:
  - `ADD`=3'b010, `SUB`=3'b110, `AND`=3'b000, `OR`=3'b001, `SLT`=3'b111.
  - Opcode and funct constants.
  - State encodings.
- One sub-module, `alu_controller`: maps `op_q`/`fn_q` to `alu_cntrl` (combinational). The FSM stays in `multi_cycle_controller`.

## Test plan
- **add:** `opcode`=000000, `funct`=100000, `mem_ready`=1.
  - `alu_cntrl`=010 from DECODE onward.
  - `reg_dst`=1 and `reg_write`=`pc_write`=`instr_done`=1 in cycle 4 only.
- **lw with wait:** `opcode`=100011, `mem_ready` low for 2 MEM cycles.
  - `mem_read` high for 3 cycles.
  - WB in cycle 7 with `mem_to_reg`=1 and `alu_src`=1.
- **beq:** `opcode`=000100.
  - `ZERO`=1 → `pc_src`=1 and `pc_write`=1 in cycle 3, `alu_cntrl`=110.
  - `ZERO`=0 → `pc_src`=0; no `reg_write` in either case.
- **jal then jr:**
  - jal: cycle 3 has `jal_reg`=`pc_to_reg`=`jump_sel`=`pc_jump`=`reg_write`=`pc_write`=1.
  - jr (`funct`=001000): cycle 3 has `jump_sel`=0, `pc_jump`=1, `reg_write`=0.
- **Reset mid-MEM:** sw with `mem_ready`=0, then `rst`=0 in MEM.
  - `mem_write` drops immediately; all outputs 0.
  - After release, FETCH resumes and `instr_done` pulses again only after a complete instruction.
- **Illegal:** `opcode`=111111.
  - With `ILLEGAL_TRAP_EN`: `illegal`=1 from cycle 3 and held; no `pc_write`.
  - Without it: `pc_write`=1 in cycle 2 and `illegal` stays 0.
